// File: rtl/irq_counter_unit.sv
// Shared mapper interrupt counter. One counter/latch pair is driven by one of four tick
// sources: CPU cycles counting down, CPU cycles counting up with reload, a 341/3 dot
// prescaler approximating scanlines, or filtered rising edges of PPU A12.
module irq_counter_unit #(
  parameter int unsigned WIDTH           = 16,
  parameter int unsigned A12_FILTER      = 3,
  parameter int unsigned PRESCALE_PERIOD = 341
) (
  input  logic             m2,
  input  logic             rst_n,
  input  logic             reg_we,
  input  logic [2:0]       reg_addr,
  input  logic [7:0]       reg_data,
  input  logic             ppu_a12,
  output logic             irq,
  output logic [WIDTH-1:0] count
);

  localparam logic [1:0] ModeCpuDown  = 2'd0;
  localparam logic [1:0] ModeCpuUp    = 2'd1;
  localparam logic [1:0] ModeScanline = 2'd2;
  localparam logic [1:0] ModeA12      = 2'd3;

  localparam logic [2:0] AddrLatchLo = 3'd0;
  localparam logic [2:0] AddrLatchHi = 3'd1;
  localparam logic [2:0] AddrCtrl    = 3'd2;
  localparam logic [2:0] AddrAck     = 3'd3;
  localparam logic [2:0] AddrReload  = 3'd4;
  localparam logic [2:0] AddrDisable = 3'd5;

  // Prescaler works in PPU dots; three dots elapse per CPU cycle.
  localparam logic [8:0] PreReload  = 9'(PRESCALE_PERIOD);
  localparam logic [8:0] PreStep    = 9'd3;
  localparam logic [8:0] PreWrapAdd = 9'(PRESCALE_PERIOD - 3);

  localparam logic [3:0]       LowMin    = 4'(A12_FILTER);
  localparam logic [3:0]       LowSat    = 4'hF;
  localparam logic [WIDTH-1:0] CountZero = '0;
  localparam logic [WIDTH-1:0] CountOne  = WIDTH'(1);
  localparam logic [WIDTH-1:0] CountMax  = '1;

  // State
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] latch_q, latch_d;
  logic [1:0]       mode_q, mode_d;
  logic             enable_q, enable_d;
  logic             enable_after_ack_q, enable_after_ack_d;
  logic             irq_q, irq_d;
  logic [8:0]       prescaler_q, prescaler_d;
  logic             reload_pending_q, reload_pending_d;
  logic             a12_s1_q, a12_s1_d;
  logic             a12_s2_q, a12_s2_d;
  logic             a12_q, a12_d;
  logic [3:0]       low_cnt_q, low_cnt_d;

  // Decoded register strobes
  logic wr_latch_lo, wr_latch_hi, wr_ctrl, wr_ack, wr_reload, wr_disable;

  // Tick plumbing
  logic             pre_run;
  logic             pre_tick;
  logic             a12_edge;
  logic             tick;
  logic             irq_set;
  logic             irq_clr;
  logic [WIDTH-1:0] a12_next;

  assign wr_latch_lo = reg_we && (reg_addr == AddrLatchLo);
  assign wr_latch_hi = reg_we && (reg_addr == AddrLatchHi);
  assign wr_ctrl     = reg_we && (reg_addr == AddrCtrl);
  assign wr_ack      = reg_we && (reg_addr == AddrAck);
  assign wr_reload   = reg_we && (reg_addr == AddrReload);
  assign wr_disable  = reg_we && (reg_addr == AddrDisable);

  // A12 synchroniser, sample stage and saturating low-time counter.
  always_comb begin
    a12_s1_d = ppu_a12;
    a12_s2_d = a12_s1_q;
    a12_d    = a12_s2_q;
    if (a12_s2_q) begin
      low_cnt_d = 4'd0;
    end else if (low_cnt_q != LowSat) begin
      low_cnt_d = low_cnt_q + 4'd1;
    end else begin
      low_cnt_d = low_cnt_q;
    end
    // Short lows from sprite fetches never build up enough count to qualify.
    a12_edge = a12_s2_q && !a12_q && (low_cnt_q >= LowMin);
  end

  // Scanline prescaler: steps 3 dots per cycle and wraps by the period.
  always_comb begin
    pre_run     = enable_q && (mode_q == ModeScanline);
    pre_tick    = pre_run && (prescaler_q <= PreStep);
    prescaler_d = prescaler_q;
    if (pre_run) begin
      if (pre_tick) begin
        prescaler_d = prescaler_q + PreWrapAdd;
      end else begin
        prescaler_d = prescaler_q - PreStep;
      end
    end
    if (wr_ctrl) begin
      prescaler_d = PreReload;
    end
  end

  // Tick source select. A12 mode counts even while disabled; only its irq is gated.
  always_comb begin
    tick = 1'b0;
    unique case (mode_q)
      ModeCpuDown:  tick = enable_q;
      ModeCpuUp:    tick = enable_q;
      ModeScanline: tick = pre_tick;
      ModeA12:      tick = a12_edge;
      default:      tick = 1'b0;
    endcase
  end

  // Counter update on a tick, then the reload strobe overrides the count.
  always_comb begin
    count_d          = count_q;
    reload_pending_d = reload_pending_q;
    irq_set          = 1'b0;
    a12_next         = count_q - CountOne;
    if (count_q == CountZero || reload_pending_q) begin
      a12_next = latch_q;
    end

    if (tick) begin
      unique case (mode_q)
        ModeCpuDown: begin
          // Holds at zero; only the 1 -> 0 step raises irq.
          if (count_q != CountZero) begin
            count_d = count_q - CountOne;
            irq_set = (count_q == CountOne);
          end
        end
        ModeCpuUp, ModeScanline: begin
          if (count_q == CountMax) begin
            count_d = latch_q;
            irq_set = 1'b1;
          end else begin
            count_d = count_q + CountOne;
          end
        end
        ModeA12: begin
          count_d          = a12_next;
          reload_pending_d = 1'b0;
          // Latch 0 therefore fires on every qualified edge.
          irq_set          = enable_q && (a12_next == CountZero);
        end
        default: ;
      endcase
    end

    if (wr_reload) begin
      if (mode_q == ModeA12) begin
        reload_pending_d = 1'b1;
      end else begin
        count_d = latch_q;
      end
    end
  end

  // Register file: latch, control bits and the interrupt flag.
  always_comb begin
    latch_d            = latch_q;
    mode_d             = mode_q;
    enable_d           = enable_q;
    enable_after_ack_d = enable_after_ack_q;

    if (wr_latch_lo) begin
      latch_d[7:0] = reg_data;
    end
    if (wr_latch_hi) begin
      // Truncation drops data bits that fall above the counter width.
      latch_d = WIDTH'({reg_data, latch_q[7:0]});
    end
    if (wr_ctrl) begin
      mode_d             = reg_data[1:0];
      enable_d           = reg_data[2];
      enable_after_ack_d = reg_data[3];
    end
    if (wr_ack) begin
      enable_d = enable_after_ack_q;
    end
    if (wr_disable) begin
      enable_d = 1'b0;
    end

    // A set in the same cycle as a clear wins so no interrupt is dropped.
    irq_clr = wr_ctrl || wr_ack || wr_disable;
    if (irq_set) begin
      irq_d = 1'b1;
    end else if (irq_clr) begin
      irq_d = 1'b0;
    end else begin
      irq_d = irq_q;
    end
  end

  // All state, synchronous active-low reset.
  always_ff @(posedge m2) begin
    if (!rst_n) begin
      count_q            <= '0;
      latch_q            <= '0;
      mode_q             <= ModeCpuDown;
      enable_q           <= 1'b0;
      enable_after_ack_q <= 1'b0;
      irq_q              <= 1'b0;
      prescaler_q        <= PreReload;
      reload_pending_q   <= 1'b0;
      a12_s1_q           <= 1'b0;
      a12_s2_q           <= 1'b0;
      a12_q              <= 1'b0;
      low_cnt_q          <= 4'd0;
    end else begin
      count_q            <= count_d;
      latch_q            <= latch_d;
      mode_q             <= mode_d;
      enable_q           <= enable_d;
      enable_after_ack_q <= enable_after_ack_d;
      irq_q              <= irq_d;
      prescaler_q        <= prescaler_d;
      reload_pending_q   <= reload_pending_d;
      a12_s1_q           <= a12_s1_d;
      a12_s2_q           <= a12_s2_d;
      a12_q              <= a12_d;
      low_cnt_q          <= low_cnt_d;
    end
  end

  assign irq   = irq_q;
  assign count = count_q;

endmodule

// File: tb/tb_irq_counter_unit.sv
// Bench for irq_counter_unit: directed scenarios plus random traffic, with every cycle's
// irq/count compared against a behavioural model through an expectation queue.
module tb_irq_counter_unit;

  localparam int W    = 8;
  localparam int F    = 3;
  localparam int P    = 341;
  localparam int MAXV = (1 << W) - 1;

  logic         m2 = 1'b0;
  logic         rst_n = 1'b0;
  logic         reg_we = 1'b0;
  logic [2:0]   reg_addr = 3'd0;
  logic [7:0]   reg_data = 8'd0;
  logic         ppu_a12 = 1'b0;
  logic         irq;
  logic [W-1:0] count;

  irq_counter_unit #(
    .WIDTH          (W),
    .A12_FILTER     (F),
    .PRESCALE_PERIOD(P)
  ) dut (
    .m2      (m2),
    .rst_n   (rst_n),
    .reg_we  (reg_we),
    .reg_addr(reg_addr),
    .reg_data(reg_data),
    .ppu_a12 (ppu_a12),
    .irq     (irq),
    .count   (count)
  );

  always #5 m2 = ~m2;

  typedef struct packed {
    logic         irq;
    logic [W-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   pin     = 1'b0;

  // Reference model state
  int m_latch, m_count, m_mode, m_pre;
  bit m_irq, m_en, m_eaa, m_pend;
  // Pin value taken at each edge; 2 marks a reset (synchroniser cleared, no low history).
  int hist[$];

  function automatic void chk(string name, int got, int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic void model_reset();
    m_latch = 0; m_count = 0; m_mode = 0; m_pre = P;
    m_irq = 0; m_en = 0; m_eaa = 0; m_pend = 0;
    hist.delete();
    hist.push_back(2);
    hist.push_back(0);
    hist.push_back(0);
  endfunction

  // Consecutive low samples seen by the synchronised signal, saturating at 15.
  function automatic int low_run();
    int n = 0;
    for (int i = hist.size() - 3; i >= 0; i--) begin
      if (hist[i] != 0) break;
      n++;
    end
    return (n > 15) ? 15 : n;
  endfunction

  function automatic bit a12_qualified();
    int n = hist.size();
    return (hist[n-2] == 1) && (hist[n-3] != 1) && (low_run() >= F);
  endfunction

  // Effect of one rising edge of m2 with the given inputs.
  function automatic void model_edge(bit rn, bit we, int addr, int data, bit a12);
    bit tick, set_irq, clr;
    int cnt;
    if (!rn) begin
      model_reset();
      return;
    end
    case (m_mode)
      0, 1:    tick = m_en;
      2:       tick = m_en && (m_pre <= 3);
      default: tick = a12_qualified();
    endcase
    if (m_mode == 2 && m_en) m_pre = (m_pre <= 3) ? m_pre + P - 3 : m_pre - 3;
    hist.push_back(int'(a12));
    if (hist.size() > 20) void'(hist.pop_front());

    cnt = m_count;
    set_irq = 0;
    if (tick) begin
      case (m_mode)
        0: if (cnt > 0) begin cnt--; set_irq = (cnt == 0); end
        1, 2: begin
          if (cnt == MAXV) begin cnt = m_latch; set_irq = 1; end
          else cnt++;
        end
        default: begin
          if (cnt == 0 || m_pend) begin cnt = m_latch; m_pend = 0; end
          else cnt--;
          set_irq = (cnt == 0) && m_en;
        end
      endcase
    end

    clr = 0;
    if (we) begin
      case (addr)
        0: m_latch = (m_latch & ~255) | data;
        1: m_latch = ((data << 8) | (m_latch & 255)) & MAXV;
        2: begin
          m_mode = data & 3; m_en = bit'((data >> 2) & 1); m_eaa = bit'((data >> 3) & 1);
          m_pre = P; clr = 1;
        end
        3: begin clr = 1; m_en = m_eaa; end
        4: if (m_mode == 3) m_pend = 1; else cnt = m_latch;
        5: begin clr = 1; m_en = 0; end
        default: ;
      endcase
    end
    m_count = cnt;
    if (set_irq) m_irq = 1;
    else if (clr) m_irq = 0;
  endfunction

  // Drive one cycle, record the model's expectation, return just after the edge.
  task automatic cyc(input bit rn, input bit we, input int addr, input int data);
    exp_t e;
    @(negedge m2);
    rst_n    = rn;
    reg_we   = we;
    reg_addr = 3'(addr);
    reg_data = 8'(data);
    ppu_a12  = pin;
    model_edge(rn, we, addr, data & 255, pin);
    e.irq = m_irq;
    e.cnt = m_count[W-1:0];
    exp_q.push_back(e);
    @(posedge m2);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    cyc(1'b1, 1'b1, addr, data);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 0, 0);
  endtask

  // Monitor: every edge, pop the expectation and compare the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      @(posedge m2);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cycle_irq", int'(irq), int'(e.irq));
        chk("cycle_count", int'(count), int'(e.cnt));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int want_gap[3];
    int gap;
    int mask;
    want_gap[0] = 114; want_gap[1] = 114; want_gap[2] = 113;

    model_reset();
    cyc(1'b0, 1'b0, 0, 0);
    cyc(1'b0, 1'b0, 0, 0);
    chk("reset_irq", int'(irq), 0);
    chk("reset_count", int'(count), 0);
    idle(4);

    // Mode 0: down-count from 5, irq on the fifth enabled cycle, then hold at zero.
    wr(0, 5);
    wr(4, 0);
    chk("m0_reload", int'(count), 5);
    wr(2, 'h04);
    for (int i = 1; i <= 5; i++) begin
      idle(1);
      chk("m0_irq_timing", int'(irq), (i == 5) ? 1 : 0);
    end
    chk("m0_zero", int'(count), 0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      chk("m0_hold", int'(count), 0);
    end
    wr(5, 0);
    chk("m0_disable_clears", int'(irq), 0);

    // Mode 1: up-count from 0xFD with auto re-enable on ack.
    wr(0, 'hFD);
    wr(4, 0);
    wr(2, 'h0D);
    idle(1); chk("m1_c1", int'(count), 'hFE); chk("m1_c1_irq", int'(irq), 0);
    idle(1); chk("m1_c2", int'(count), 'hFF); chk("m1_c2_irq", int'(irq), 0);
    idle(1); chk("m1_c3_irq", int'(irq), 1); chk("m1_c3_count", int'(count), 'hFD);
    wr(3, 0); chk("m1_ack_irq", int'(irq), 0); chk("m1_ack_count", int'(count), 'hFE);
    idle(2); chk("m1_second_irq", int'(irq), 1); chk("m1_second_count", int'(count), 'hFD);
    idle(2);
    wr(3, 0);
    chk("ack_vs_tick_irq", int'(irq), 1);
    chk("ack_vs_tick_count", int'(count), 'hFD);
    wr(3, 0);
    chk("ack_clears", int'(irq), 0);
    wr(4, 0);
    chk("reload_vs_tick", int'(count), 'hFD);
    wr(5, 0);

    // Mode 2: prescaled ticks at 114/114/113 cycle spacing.
    wr(0, 'hFF);
    wr(4, 0);
    chk("m2_preload", int'(count), 'hFF);
    wr(2, 'h0E);
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      if (k > 0) begin
        wr(3, 0);
        gap = 1;
      end
      while (irq !== 1'b1 && gap < 200) begin
        idle(1);
        gap++;
      end
      chk($sformatf("m2_spacing%0d", k), gap, want_gap[k]);
    end
    chk("m2_count_reloaded", int'(count), 'hFF);

    // Reset mid-count with irq pending.
    idle(5);
    cyc(1'b0, 1'b0, 0, 0);
    chk("rst_irq", int'(irq), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_prescaler", int'(dut.prescaler_q), P);
    chk("rst_enable", int'(dut.enable_q), 0);
    chk("rst_mode", int'(dut.mode_q), 0);
    idle(6);

    // Mode 3: latch 2, eight well-separated A12 pulses.
    wr(0, 2);
    wr(2, 'h0F);
    wr(4, 0);
    chk("m3_pending_only", int'(count), 0);
    mask = 0;
    for (int p = 0; p < 8; p++) begin
      pin = 1'b1; idle(2);
      pin = 1'b0; idle(4);
      if (irq === 1'b1) begin
        mask |= (1 << p);
        wr(3, 0);
      end else begin
        idle(1);
      end
    end
    chk("m3_irq_pattern", mask, 'h24);
    chk("m3_count_after8", int'(count), 1);

    pin = 1'b1; idle(4);
    chk("m3_edge_to_zero", int'(count), 0);
    chk("m3_edge_irq", int'(irq), 1);
    wr(3, 0);
    for (int g = 0; g < 5; g++) begin
      pin = 1'b0; idle(1);
      pin = 1'b1; idle(2);
    end
    chk("a12_short_low", int'(count), 0);
    for (int g = 0; g < 2; g++) begin
      pin = 1'b0; idle(2);
      pin = 1'b1; idle(2);
    end
    chk("a12_low_below_filter", int'(count), 0);
    pin = 1'b0; idle(3);
    pin = 1'b1; idle(4);
    chk("a12_low_at_filter", int'(count), 2);
    chk("a12_low_at_filter_irq", int'(irq), 0);

    wr(5, 0);
    pin = 1'b0; idle(4);
    pin = 1'b1; idle(4);
    chk("m3_disabled_counts", int'(count), 1);
    chk("m3_disabled_no_irq", int'(irq), 0);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      bit rn, we;
      rn = ($urandom_range(0, 199) != 0);
      we = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) pin = ~pin;
      cyc(rn, we, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
    end

    @(negedge m2);
    chk("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
